// File: rtl/stack_cpu_mem_if.sv
// Single-port instruction/data memory bus for stack_cpu_core.
// A request (mem_rd or mem_wr) holds mem_addr and mem_wdata steady until the memory answers with mem_ready.
interface stack_cpu_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/stack_cpu_core.sv
// Multicycle stack-machine CPU. It has a controller FSM, a datapath and an internal operand stack.
// Stack overflow or underflow stops the core with a sticky halt.
// Optional STACK_CPU_PERF_EN adds the retired / retired_cnt instruction counters.
module stack_cpu_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    stack_cpu_mem_if.master        mem,
    output logic [ADDR_W-1:0]      pc,
    output logic                   halted,
    output logic [1:0]             fault_code
`ifdef STACK_CPU_PERF_EN
    ,
    output logic                   retired,
    output logic [31:0]            retired_cnt
`endif
);
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_NOT = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100, OP_POP = 3'b101, OP_JMP = 3'b110, OP_JZ = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_POP_A, S_POP_B, S_PUSH_RES, S_MEM_RD, S_MEM_WR, S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [1:0]        fault_q, fault_d;

    logic [DATA_W-1:0] stack_q [STACK_DEPTH];
    logic              stack_we;
    logic [IDXW-1:0]   stack_widx;
    logic [DATA_W-1:0] stack_wdata;

    logic              req_rd, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              underflow, overflow;
    logic [DATA_W-1:0] alu_res;

    logic [2:0]        op;
    logic [ADDR_W-1:0] op_addr;
    logic [IDXW-1:0]   tos_idx, push_idx;
    logic [DATA_W-1:0] tos;
    logic              unused_ir;

    assign op        = ir_q[DATA_W-1 -: 3];
    assign op_addr   = ir_q[ADDR_W-1:0];
    assign unused_ir = ^{1'b0, ir_q};
    assign tos_idx   = IDXW'(sp_q - SPW'(1));
    assign push_idx  = IDXW'(sp_q);
    assign tos       = stack_q[tos_idx];

    always_comb begin
        case (op)
            OP_ADD:  alu_res = b_q + a_q;
            OP_SUB:  alu_res = b_q - a_q;
            OP_AND:  alu_res = b_q & a_q;
            default: alu_res = ~a_q;
        endcase
    end

    always_comb begin
        underflow = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND: underflow = (sp_q < SPW'(2));
            OP_NOT, OP_POP, OP_JZ:  underflow = (sp_q == '0);
            OP_PUSH:                overflow  = (sp_q == SPW'(STACK_DEPTH));
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        fault_d     = fault_q;
        req_rd      = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        stack_we    = 1'b0;
        stack_widx  = push_idx;
        stack_wdata = alu_res;
        case (state_q)
            S_FETCH: begin
                req_rd   = 1'b1;
                req_addr = pc_q;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (underflow) begin
                    fault_d = 2'b10;
                    state_d = S_HALT;
                end else if (overflow) begin
                    fault_d = 2'b01;
                    state_d = S_HALT;
                end else begin
                    case (op)
                        OP_JMP: begin
                            pc_d    = op_addr;
                            state_d = S_FETCH;
                        end
                        OP_JZ: begin
                            if (tos == '0) pc_d = op_addr;
                            state_d = S_FETCH;
                        end
                        OP_PUSH: state_d = S_MEM_RD;
                        default: state_d = S_POP_A;
                    endcase
                end
            end
            S_POP_A: begin
                a_d  = tos;
                sp_d = sp_q - SPW'(1);
                if (op == OP_NOT)      state_d = S_PUSH_RES;
                else if (op == OP_POP) state_d = S_MEM_WR;
                else                   state_d = S_POP_B;
            end
            S_POP_B: begin
                b_d     = tos;
                sp_d    = sp_q - SPW'(1);
                state_d = S_PUSH_RES;
            end
            S_PUSH_RES: begin
                stack_we = 1'b1;
                sp_d     = sp_q + SPW'(1);
                state_d  = S_FETCH;
            end
            S_MEM_RD: begin
                req_rd   = 1'b1;
                req_addr = op_addr;
                if (mem.mem_ready) begin
                    stack_we    = 1'b1;
                    stack_wdata = mem.mem_rdata;
                    sp_d        = sp_q + SPW'(1);
                    state_d     = S_FETCH;
                end
            end
            S_MEM_WR: begin
                req_wr    = 1'b1;
                req_addr  = op_addr;
                req_wdata = a_q;
                if (mem.mem_ready) state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sp_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fault_q <= fault_d;
        end
    end

    // Stack storage is deliberately unreset; the DECODE depth check guards every read.
    always_ff @(posedge clk) begin
        if (stack_we) stack_q[stack_widx] <= stack_wdata;
    end

    // Requests are gated by rst so an abandoned access drops at once, not at the next edge.
    assign mem.mem_rd    = req_rd & ~rst;
    assign mem.mem_wr    = req_wr & ~rst;
    assign mem.mem_addr  = rst ? '0 : req_addr;
    assign mem.mem_wdata = rst ? '0 : req_wdata;

    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign fault_code = fault_q;

`ifdef STACK_CPU_PERF_EN
    logic        retired_q, retired_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_d     = (state_d == S_FETCH) &&
                        (state_q == S_DECODE || state_q == S_PUSH_RES ||
                         state_q == S_MEM_RD || state_q == S_MEM_WR);
        retired_cnt_d = retired_cnt_q + 32'(retired_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q     <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            retired_q     <= retired_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired     = retired_q;
    assign retired_cnt = retired_cnt_q;
`endif
endmodule

// File: tb/tb_stack_cpu_core.sv
// Scoreboard bench for stack_cpu_core.
// The main core runs directed programs against a wait-state memory model; a second core with a two-entry stack checks overflow.
module tb_stack_cpu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    stack_cpu_mem_if #(.DATA_W(8), .ADDR_W(5)) mif ();
    stack_cpu_mem_if #(.DATA_W(8), .ADDR_W(5)) mif2 ();

    logic [4:0] pc, pc2;
    logic       halted, halted2;
    logic [1:0] fault_code, fault_code2;
`ifdef STACK_CPU_PERF_EN
    logic        retired, retired2;
    logic [31:0] retired_cnt, retired_cnt2;
`endif

    stack_cpu_core #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .mem(mif), .pc(pc), .halted(halted), .fault_code(fault_code)
`ifdef STACK_CPU_PERF_EN
        , .retired(retired), .retired_cnt(retired_cnt)
`endif
    );

    stack_cpu_core #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .mem(mif2), .pc(pc2), .halted(halted2), .fault_code(fault_code2)
`ifdef STACK_CPU_PERF_EN
        , .retired(retired2), .retired_cnt(retired_cnt2)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wait_n = 0;
    int wcnt = 0;

    logic [7:0] prog [32];
    logic [7:0] mem  [32];
    logic [7:0] prog2 [32];

    typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
    wr_t expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: it is loaded from prog while rst is high, and mem_ready rises after wait_n stall cycles.
    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= prog[i];
        end else if (mif.mem_rd || mif.mem_wr) begin
            if (mif.mem_ready) begin
                if (mif.mem_wr) mem[mif.mem_addr] <= mif.mem_wdata;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end
    assign mif.mem_ready = (mif.mem_rd || mif.mem_wr) && (wcnt >= wait_n);
    assign mif.mem_rdata = mem[mif.mem_addr];
    assign mif2.mem_ready = 1'b1;
    assign mif2.mem_rdata = prog2[mif2.mem_addr];

    // Monitor: it checks writes against the scoreboard and checks that requests stay stable while waiting.
    logic       held = 1'b0;
    logic [4:0] prev_addr = '0;
    logic [1:0] prev_op = '0;
    int rd_acc = 0, wr_acc = 0, rd2_acc = 0;
    int fetch_cyc [8];

    always @(negedge clk) begin
        if (rst) begin
            held   <= 1'b0;
            rd_acc <= 0;
            wr_acc <= 0;
        end else begin
            if (held) begin
                check("hold_addr", 32'(mif.mem_addr), 32'(prev_addr));
                check("hold_req", 32'({mif.mem_rd, mif.mem_wr}), 32'(prev_op));
            end
            if (mif.mem_wr && mif.mem_ready) begin
                wr_acc <= wr_acc + 1;
                if (expq.size() == 0) begin
                    check("unexpected_wr", 32'(mif.mem_addr), 32'h0);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    check("wr_addr", 32'(mif.mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mif.mem_wdata), 32'(e.data));
                end
            end
            if (mif.mem_rd && mif.mem_ready) begin
                rd_acc <= rd_acc + 1;
                if (mif.mem_addr < 5'd8) fetch_cyc[mif.mem_addr[2:0]] <= cyc;
            end
            held      <= (mif.mem_rd || mif.mem_wr) && !mif.mem_ready;
            prev_addr <= mif.mem_addr;
            prev_op   <= {mif.mem_rd, mif.mem_wr};
        end
        if (!rst2 && mif2.mem_rd) rd2_acc <= rd2_acc + 1;
    end

    task automatic clear_prog();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    task automatic load_p1();
        clear_prog();
        prog[0] = 8'h8A; prog[1] = 8'h8B; prog[2] = 8'h20; prog[3] = 8'hAC; prog[4] = 8'hC4;
        prog[10] = 8'd9; prog[11] = 8'd4;
    endtask

    task automatic do_reset(input int wn);
        rst = 1'b1;
        wait_n = wn;
        repeat (2) @(negedge clk);
        check("rst_mem_rd", 32'(mif.mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mif.mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mif.mem_wdata), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_sp", 32'(dut.sp_q), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault_code), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) prog2[i] = 8'h00;
        prog2[0] = 8'h8A; prog2[1] = 8'h8A; prog2[2] = 8'h8A; prog2[10] = 8'd7;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;

        // The SUB program runs with zero-wait memory.
        load_p1();
        do_reset(0);
        expq.push_back('{addr: 5'd12, data: 8'd5});
        repeat (40) @(negedge clk);
        check("p1_mem12", 32'(mem[12]), 32'd5);
        check("p1_wr_count", 32'(wr_acc), 32'd1);
        check("p1_sub_cycles", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd5);
        check("p1_pc_loop", 32'(pc == 5'd4 || pc == 5'd5), 32'd1);
        check("p1_sb_empty", 32'(expq.size()), 32'd0);

        // The same program runs with 3 wait states on every request.
        load_p1();
        do_reset(3);
        expq.push_back('{addr: 5'd12, data: 8'd5});
        repeat (100) @(negedge clk);
        check("p2_mem12", 32'(mem[12]), 32'd5);
        check("p2_wr_count", 32'(wr_acc), 32'd1);
        check("p2_sub_cycles", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd8);
        check("p2_sb_empty", 32'(expq.size()), 32'd0);

        // ADD on an empty stack gives an underflow halt.
        clear_prog();
        do_reset(0);
        @(negedge clk);
        check("uf_halted_c1", 32'(halted), 32'd0);
        @(negedge clk);
        check("uf_halted_c2", 32'(halted), 32'd1);
        check("uf_fault", 32'(fault_code), 32'h2);
        repeat (10) @(negedge clk);
        check("uf_rd_count", 32'(rd_acc), 32'd1);
        check("uf_pc_frozen", 32'(pc), 32'd1);

        // JZ is taken when TOS is 0.
        clear_prog();
        prog[0] = 8'h8A; prog[1] = 8'hE7; prog[7] = 8'hC7; prog[2] = 8'hC2; prog[10] = 8'd0;
        do_reset(0);
        repeat (5) @(negedge clk);
        check("jz0_pc", 32'(pc), 32'd7);
        check("jz0_sp", 32'(dut.sp_q), 32'd1);

        // JZ falls through when TOS is nonzero.
        clear_prog();
        prog[0] = 8'h8A; prog[1] = 8'hE7; prog[7] = 8'hC7; prog[2] = 8'hC2; prog[10] = 8'd3;
        do_reset(0);
        repeat (5) @(negedge clk);
        check("jz3_pc", 32'(pc), 32'd2);
        check("jz3_sp", 32'(dut.sp_q), 32'd1);

        // Reset is asserted during a MEM_WR wait, then execution restarts.
        load_p1();
        do_reset(3);
        begin
            int k;
            k = 0;
            while (!mif.mem_wr && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("mw_wr_seen", 32'(mif.mem_wr), 32'd1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mw_wr_drop", 32'(mif.mem_wr), 32'd0);
        check("mw_pc", 32'(pc), 32'd0);
        check("mw_sp", 32'(dut.sp_q), 32'd0);
        check("mw_mem12_untouched", 32'(mem[12]), 32'd0);
        do_reset(0);
        expq.push_back('{addr: 5'd12, data: 8'd5});
        repeat (40) @(negedge clk);
        check("mw_restart_mem12", 32'(mem[12]), 32'd5);
        check("mw_sb_empty", 32'(expq.size()), 32'd0);

        // The STACK_DEPTH=2 core has been running the three-PUSH program since the start.
        check("ov_halted", 32'(halted2), 32'd1);
        check("ov_fault", 32'(fault_code2), 32'h1);
        check("ov_sp", 32'(dut2.sp_q), 32'd2);
        check("ov_rd_count", 32'(rd2_acc), 32'd5);
        check("ov_pc", 32'(pc2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_cpu_core.md
Name: stack_cpu_core

Overview:
- Parametrised multicycle stack-machine CPU core: controller FSM, datapath and an internal hardware operand stack in one block.
- Generalises the fixed 8-bit stack CPU in three ways:
  - configurable data width, address width and stack depth;
  - external memory with a ready handshake, so wait states are allowed;
  - overflow/underflow detection with a sticky halt.
- Sits between the system top and a single-port instruction/data memory.

Parameters:
- DATA_W, 8: data and instruction word width; must be >= ADDR_W+3.
- ADDR_W, 5: memory address width, which is also the PC width.
- STACK_DEPTH, 8: number of stack entries; must be >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request on this edge.
- pc  out  ADDR_W  current program counter.
- halted  out  1  core stopped on a fault; sticky.
- fault_code  out  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Reset (async, any state, including mid-memory-access):
  - pc=0, sp=0, state=FETCH, halted=0, fault_code=00, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Any pending memory access is abandoned.
- Instruction word format:
  - IR[DATA_W-1:DATA_W-3] = opcode.
  - IR[ADDR_W-1:0] = operand address.
  - Remaining bits are ignored.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 NOT.
  - 100 PUSH addr: push mem[addr].
  - 101 POP addr: pop to mem[addr].
  - 110 JMP addr.
  - 111 JZ addr: jump if TOS==0; does not pop.
- Binary operations: A<=pop (TOS), then B<=pop, then push (B op A). SUB yields NOS-TOS. Arithmetic is modulo 2^DATA_W with no flags.
- Memory handshake:
  - mem_rd/mem_wr asserted combinationally from state; never both high together.
  - mem_addr and mem_wdata held stable until an edge with mem_ready=1.
  - The state then advances, so the request drops in the next cycle.
  - mem_ready is ignored when no request is active.
- FSM states and transitions:
  - FETCH: mem_rd=1, mem_addr=pc. On ready: IR<=mem_rdata, pc<=pc+1 (wraps from all-ones to 0), go to DECODE.
  - DECODE performs the stack check; a failing check goes to HALT with no state change. Checks:
    - ADD/SUB/AND need sp>=2.
    - NOT, POP and JZ need sp>=1.
    - PUSH needs sp<STACK_DEPTH.
  - DECODE, passing check, dispatch:
    - JMP: pc<=addr, go to FETCH.
    - JZ: if TOS==0 then pc<=addr; go to FETCH.
    - ALU ops: go to POP_A.
    - PUSH: go to MEM_RD.
    - POP: go to POP_A.
  - POP_A: A<=TOS, sp--. Binary ops go to POP_B; NOT goes to PUSH_RES; POP goes to MEM_WR.
  - POP_B: B<=TOS, sp-- → PUSH_RES.
  - PUSH_RES: stack[sp]<=result, sp++ → FETCH.
  - MEM_RD: mem_rd=1, mem_addr=addr. On ready: stack[sp]<=mem_rdata, sp++ → FETCH.
  - MEM_WR: mem_wr=1, mem_addr=addr, mem_wdata=A. On ready → FETCH.
  - HALT: no requests issued; pc and stack frozen until rst.
    - Overflow sets fault_code=01; underflow sets 10.
    - halted=1 from the cycle after DECODE.
- Zero-wait latency, in cycles: ADD/SUB/AND 5, NOT 4, PUSH 3, POP 4, JMP/JZ 2. Each memory wait cycle adds one.
- sp range is 0..STACK_DEPTH. Stack contents are not reset; a read of an empty slot never occurs because of the DECODE check.

Optional Feature:
- Macro: STACK_CPU_PERF_EN.
- When defined, adds two outputs:
  - retired  out  1: one-cycle pulse on the edge each instruction completes (the transition into FETCH from DECODE, PUSH_RES, MEM_RD or MEM_WR).
  - retired_cnt  out  32: wrapping count of those pulses; reset to 0, frozen in HALT.
- When not defined, both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Memory = [PUSH 10, PUSH 11, SUB, POP 12, JMP 4], mem[10]=9, mem[11]=4, mem_ready=1 → mem[12]=5; mem_wr seen once with addr 12, wdata 5; SUB takes 5 cycles; pc loops at 4.
- Same program with mem_ready low 3 cycles on each request → identical result; mem_rd held with a stable address throughout each wait.
- STACK_DEPTH=2, program of three PUSHes → halted=1, fault_code=01, sp=2, no third mem_rd issued.
- First instruction ADD on an empty stack → halted=1, fault_code=10 two cycles after reset release; no further mem_rd.
- PUSH of a 0 value then JZ 7 → pc=7 and stack depth still 1. Repeat with value 3 → pc falls through to 2.
- Assert rst during a MEM_WR wait → mem_wr drops immediately; pc=0, sp=0; execution restarts at address 0.
